// File: rtl/best_hop_select.sv
// Next-hop selector: scans neighbour qValues in node memory, picks the best eligible hop and writes the node's own value.
// Optional battery filter enabled by defining BEST_HOP_BATT_FILTER_EN.
module best_hop_select #(
  parameter int                    WORD_WIDTH = 16,
  parameter logic [WORD_WIDTH-1:0] HOP_COST   = 16'd1,
  parameter logic [WORD_WIDTH-1:0] BATT_MIN   = 16'd10
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [WORD_WIDTH-1:0] best_id,
  output logic [WORD_WIDTH-1:0] best_q
);

  localparam logic [WORD_WIDTH-1:0] ADDR_CNT  = 16'h068A;
  localparam logic [WORD_WIDTH-1:0] ADDR_ID   = 16'h0048;
  localparam logic [WORD_WIDTH-1:0] ADDR_BATT = 16'h0148;
  localparam logic [WORD_WIDTH-1:0] ADDR_Q    = 16'h01C8;
  localparam logic [WORD_WIDTH-1:0] ADDR_OWN  = 16'h068C;
  localparam logic [WORD_WIDTH-1:0] ZERO_W    = {WORD_WIDTH{1'b0}};
  localparam logic [WORD_WIDTH-1:0] ONES_W    = {WORD_WIDTH{1'b1}};
  localparam logic [WORD_WIDTH-1:0] ONE_W     = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_CNT = 3'd1,
    S_Q_ADDR = 3'd2,
    S_Q_LAT  = 3'd3,
`ifdef BEST_HOP_BATT_FILTER_EN
    S_B_EVAL = 3'd6,
`endif
    S_ID_LAT = 3'd4,
    S_WR     = 3'd5
  } state_t;

  state_t                state_r;
  logic [WORD_WIDTH-1:0] n_r;
  logic [WORD_WIDTH-1:0] cnt_r;
  logic [WORD_WIDTH-1:0] cand_q_r;
  logic [WORD_WIDTH-1:0] cand_idx_r;
  logic                  cand_found_r;
`ifdef BEST_HOP_BATT_FILTER_EN
  logic [WORD_WIDTH-1:0] q_r;
`endif

  logic [WORD_WIDTH-1:0] eval_q_s;
  logic                  eligible_s;
  logic                  replace_s;
  logic [WORD_WIDTH-1:0] own_value_s;

  function automatic logic [WORD_WIDTH-1:0] sat_sub(input logic [WORD_WIDTH-1:0] a,
                                                    input logic [WORD_WIDTH-1:0] b);
    return (a >= b) ? (a - b) : ZERO_W;
  endfunction

  function automatic logic batt_ok(input logic [WORD_WIDTH-1:0] batt);
    return batt >= BATT_MIN;
  endfunction

  function automatic logic [WORD_WIDTH-1:0] word_offset(input logic [WORD_WIDTH-1:0] base,
                                                        input logic [WORD_WIDTH-1:0] idx);
    return base + {idx[WORD_WIDTH-2:0], 1'b0};
  endfunction

  // Candidate evaluation and own-value computation
  always_comb begin
`ifdef BEST_HOP_BATT_FILTER_EN
    eval_q_s   = q_r;
    eligible_s = batt_ok(data_in);
`else
    eval_q_s   = data_in;
    eligible_s = 1'b1;
`endif
    replace_s   = eligible_s && (!cand_found_r || (eval_q_s > cand_q_r));
    own_value_s = cand_found_r ? sat_sub(cand_q_r, HOP_COST) : ZERO_W;
  end

  // Scan sequencer with registered memory and result outputs
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      address      <= ZERO_W;
      data_out     <= ZERO_W;
      wr_en        <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      found        <= 1'b0;
      best_id      <= ONES_W;
      best_q       <= ZERO_W;
      n_r          <= ZERO_W;
      cnt_r        <= ZERO_W;
      cand_q_r     <= ZERO_W;
      cand_idx_r   <= ZERO_W;
      cand_found_r <= 1'b0;
`ifdef BEST_HOP_BATT_FILTER_EN
      q_r          <= ZERO_W;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            address      <= ADDR_CNT;
            n_r          <= ZERO_W;
            cand_found_r <= 1'b0;
            cand_q_r     <= ZERO_W;
            cand_idx_r   <= ZERO_W;
            busy         <= 1'b1;
            state_r      <= S_LD_CNT;
          end else begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_LD_CNT: begin
          cnt_r   <= data_in;
          state_r <= S_Q_ADDR;
        end
        S_Q_ADDR: begin
          if (n_r == cnt_r) begin
            address <= word_offset(ADDR_ID, cand_idx_r);
            state_r <= S_ID_LAT;
          end else begin
            address <= word_offset(ADDR_Q, n_r);
            state_r <= S_Q_LAT;
          end
        end
        S_Q_LAT: begin
`ifdef BEST_HOP_BATT_FILTER_EN
          q_r     <= data_in;
          address <= word_offset(ADDR_BATT, n_r);
          state_r <= S_B_EVAL;
`else
          if (replace_s) begin
            cand_q_r     <= eval_q_s;
            cand_idx_r   <= n_r;
            cand_found_r <= 1'b1;
          end
          n_r     <= n_r + ONE_W;
          state_r <= S_Q_ADDR;
`endif
        end
`ifdef BEST_HOP_BATT_FILTER_EN
        S_B_EVAL: begin
          if (replace_s) begin
            cand_q_r     <= eval_q_s;
            cand_idx_r   <= n_r;
            cand_found_r <= 1'b1;
          end
          n_r     <= n_r + ONE_W;
          state_r <= S_Q_ADDR;
        end
`endif
        S_ID_LAT: begin
          // The ID read happens even with no candidate; it is discarded then.
          found    <= cand_found_r;
          best_id  <= cand_found_r ? data_in : ONES_W;
          best_q   <= cand_found_r ? cand_q_r : ZERO_W;
          address  <= ADDR_OWN;
          data_out <= own_value_s;
          wr_en    <= 1'b1;
          state_r  <= S_WR;
        end
        S_WR: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
